// File: rtl/mac_pe_if.sv
// Operand/accumulator bundle for one systolic MAC cell.
// The cell takes the slave side. The array wiring or the bench takes the master side.
interface mac_pe_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32
);
    logic [DATA_W-1:0] a_in;
    logic [DATA_W-1:0] b_in;
    logic              valid;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;
    logic [ACC_W-1:0]  product;

    modport master (
        output a_in, b_in, valid,
        input  a_out, b_out, product
    );

    modport slave (
        input  a_in, b_in, valid,
        output a_out, b_out, product
    );
endinterface

// File: rtl/mac_pe.sv
// Output-stationary MAC cell. It accumulates a_in*b_in and forwards the operands
// east and south with a one-cycle register delay.
module mac_pe #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 32
) (
    input logic    clk,
    input logic    reset,
    mac_pe_if.slave bus
);
    localparam int unsigned PROD_W = 2 * DATA_W;

    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [ACC_W-1:0]  acc_q;
    logic [PROD_W-1:0] prod_c;

    // The full-width unsigned product is zero-extended into the accumulator.
    // The sum wraps modulo 2^ACC_W.
    assign prod_c = PROD_W'(bus.a_in) * PROD_W'(bus.b_in);

    // Reset discards any partial sum. Accumulation restarts only through reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
        end else if (bus.valid) begin
            a_q   <= bus.a_in;
            b_q   <= bus.b_in;
            acc_q <= acc_q + ACC_W'(prod_c);
        end
    end

    assign bus.a_out   = a_q;
    assign bus.b_out   = b_q;
    assign bus.product = acc_q;
endmodule

// File: tb/tb_mac_pe.sv
// Bench for mac_pe. It checks a single cell against a reference model and a
// skew-fed 2x2 array against a matrix product.
module tb_mac_pe;
    localparam int unsigned DATA_W = 16;
    localparam int unsigned ACC_W  = 32;

    typedef struct packed {
        logic [ACC_W-1:0]  acc;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } exp_t;

    logic clk;
    logic reset;
    logic arr_valid;

    int checks   = 0;
    int failures = 0;

    exp_t             sb_q[$];
    logic [ACC_W-1:0] arr_q[$];

    logic [ACC_W-1:0]  m_acc;
    logic [DATA_W-1:0] m_a;
    logic [DATA_W-1:0] m_b;

    logic [DATA_W-1:0] ma[2][2];
    logic [DATA_W-1:0] mb[2][2];

    mac_pe_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) s_if ();
    mac_pe_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) if00 ();
    mac_pe_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) if01 ();
    mac_pe_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) if10 ();
    mac_pe_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) if11 ();

    mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_dut  (.clk(clk), .reset(reset), .bus(s_if));
    mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe00 (.clk(clk), .reset(reset), .bus(if00));
    mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe01 (.clk(clk), .reset(reset), .bus(if01));
    mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe10 (.clk(clk), .reset(reset), .bus(if10));
    mac_pe #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_pe11 (.clk(clk), .reset(reset), .bus(if11));

    // Systolic chaining: a flows east and b flows south.
    assign if01.a_in  = if00.a_out;
    assign if11.a_in  = if10.a_out;
    assign if10.b_in  = if00.b_out;
    assign if11.b_in  = if01.b_out;
    assign if00.valid = arr_valid;
    assign if01.valid = arr_valid;
    assign if10.valid = arr_valid;
    assign if11.valid = arr_valid;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one cycle on the single cell, model it, then compare after the edge.
    task automatic step(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b, input logic v);
        exp_t e;
        @(negedge clk);
        s_if.a_in  = a;
        s_if.b_in  = b;
        s_if.valid = v;
        if (v) begin
            m_acc = m_acc + (ACC_W'(a) * ACC_W'(b));
            m_a   = a;
            m_b   = b;
        end
        e.acc = m_acc;
        e.a   = m_a;
        e.b   = m_b;
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check("product", 64'(s_if.product), 64'(e.acc));
        check("a_out",   64'(s_if.a_out),   64'(e.a));
        check("b_out",   64'(s_if.b_out),   64'(e.b));
    endtask

    // Assert reset between edges and confirm every output clears before any clock.
    task automatic pulse_reset(input string tag);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check({tag, "_product"}, 64'(s_if.product), 64'd0);
        check({tag, "_a_out"},   64'(s_if.a_out),   64'd0);
        check({tag, "_b_out"},   64'(s_if.b_out),   64'd0);
        check({tag, "_pe11"},    64'(if11.product), 64'd0);
        m_acc = '0;
        m_a   = '0;
        m_b   = '0;
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Skew-feed ma x mb into the array with zero padding, then compare all four cells.
    task automatic run_array(input string tag);
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                arr_q.push_back(ACC_W'(ma[i][0]) * ACC_W'(mb[0][j])
                              + ACC_W'(ma[i][1]) * ACC_W'(mb[1][j]));
        for (int t = 0; t < 6; t++) begin
            @(negedge clk);
            arr_valid = 1'b1;
            if00.a_in = (t < 2) ? ma[0][t] : '0;
            if00.b_in = (t < 2) ? mb[t][0] : '0;
            if10.a_in = (t >= 1 && t < 3) ? ma[1][t-1] : '0;
            if01.b_in = (t >= 1 && t < 3) ? mb[t-1][1] : '0;
        end
        @(posedge clk);
        #1;
        check({tag, "_pe00"}, 64'(if00.product), 64'(arr_q.pop_front()));
        check({tag, "_pe01"}, 64'(if01.product), 64'(arr_q.pop_front()));
        check({tag, "_pe10"}, 64'(if10.product), 64'(arr_q.pop_front()));
        check({tag, "_pe11"}, 64'(if11.product), 64'(arr_q.pop_front()));
        @(negedge clk);
        arr_valid = 1'b0;
    endtask

    initial begin
        reset      = 1'b1;
        arr_valid  = 1'b0;
        s_if.a_in  = '0;
        s_if.b_in  = '0;
        s_if.valid = 1'b0;
        if00.a_in  = '0;
        if00.b_in  = '0;
        if10.a_in  = '0;
        if01.b_in  = '0;
        m_acc      = '0;
        m_a        = '0;
        m_b        = '0;
        #12;
        check("rst_product", 64'(s_if.product), 64'd0);
        check("rst_a_out",   64'(s_if.a_out),   64'd0);
        @(negedge clk);
        reset = 1'b0;

        step(16'd1, 16'd5, 1'b1);
        check("seq_p5",  64'(s_if.product), 64'd5);
        step(16'd2, 16'd7, 1'b1);
        check("seq_p19", 64'(s_if.product), 64'd19);
        step(16'd0, 16'd0, 1'b1);
        check("seq_zero", 64'(s_if.product), 64'd19);

        for (int i = 0; i < 3; i++) step(16'd9, 16'd9, 1'b0);
        check("hold_p19", 64'(s_if.product), 64'd19);
        check("hold_a0",  64'(s_if.a_out),   64'd0);

        pulse_reset("midrst");

        step(16'hFFFF, 16'hFFFF, 1'b1);
        check("wrap1", 64'(s_if.product), 64'hFFFE0001);
        step(16'hFFFF, 16'hFFFF, 1'b1);
        check("wrap2", 64'(s_if.product), 64'hFFFC0002);

        for (int i = 0; i < 10; i++)
            step(DATA_W'($urandom), DATA_W'($urandom), 1'($urandom_range(0, 1)));

        pulse_reset("prearr");
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++) begin
                ma[i][j] = DATA_W'($urandom_range(1, 300));
                mb[i][j] = DATA_W'($urandom_range(1, 300));
            end
        run_array("rand");

        pulse_reset("between");
        ma[0][0] = 16'd1; ma[0][1] = 16'd2; ma[1][0] = 16'd3; ma[1][1] = 16'd4;
        mb[0][0] = 16'd5; mb[0][1] = 16'd6; mb[1][0] = 16'd7; mb[1][1] = 16'd8;
        run_array("mat");
        check("c00", 64'(if00.product), 64'd19);
        check("c11", 64'(if11.product), 64'd50);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
